pendig_layer1: RTL and testbench
================================

# pendig_layer1

First hidden layer of the pen-digits binarized neural network. Takes 16 unsigned 7-bit features, computes 16 binary-weighted (±1) dot products, and thresholds each into one hidden bit (batch-norm folded into a per-neuron threshold). A second, fused compare path must agree with the reference path. A mismatch flag exposes any disagreement. Feeds the downstream XNOR-popcount output layer.

## Interface
Parameters:
- WEIGHTS, 256'hFFFF…FFFF (all ones): bit [i*16+j] is the weight of neuron i on feature j; 1 = +1, 0 = −1.
- THRESH, 176'h0: per-neuron signed 11-bit threshold at [i*11+:11].

Ports:
- clk  in  1  single clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  feat is sampled on this cycle.
- feat  in  112  feature j at [j*7+:7], unsigned 0..127; feature 0 in the LSBs.
- out_valid  out  1  outputs below are valid.
- acc  out  176  neuron i signed 11-bit accumulator at [i*11+:11], saturated.
- hbits  out  16  thresholded hidden bits, reference path; bit i = neuron i.
- hbits_fused  out  16  same bits, fused path.
- mismatch  out  1  hbits != hbits_fused.

## Operation
- Full-precision sum per neuron: s_i = Σ_j (W[i][j] ? +f_j : −f_j), computed in 12-bit signed. Range is −2032..2032.
- acc_i = s_i saturated to [−1024, 1023].
- Reference path: hbits[i] = (s_i >= sign-extended THRESH_i). The compare uses the unsaturated s_i.
- Fused path: P_i = Σ f_j over W=1 and N_i = Σ f_j over W=0, both unsigned 11-bit. hbits_fused[i] = (P_i >= N_i + THRESH_i), evaluated in 13-bit signed.
- Both paths must be mathematically identical. mismatch is a verification aid only and must be 0 for every input and parameter set.
- Ties at the threshold produce 1.
- Every computation is combinational from one registered input vector. No state beyond the pipeline registers.

## Timing
- Reset (rst_n low, asynchronous) clears the input register, acc, hbits, hbits_fused, mismatch and out_valid to 0 immediately. Clearing is independent of clk.
- Latency is 1 cycle:
  - feat is captured on the clk edge where in_valid=1.
  - All outputs are registered on the next edge.
  - out_valid=1 for exactly one cycle per accepted input.
- Back-to-back in_valid is accepted every cycle, giving throughput of 1 vector per clock.
- When in_valid=0, outputs hold their last values and out_valid=0.
- If reset is asserted mid-operation, any in-flight vector is discarded. The first out_valid after release corresponds to the first in_valid sampled after release.

## Test plan
Stimulus vector V, listed as f0..f15: 80,100,18,98,60,66,100,29,42,0,0,23,42,61,56,98. Its total is 873.
- Default params (all +1, threshold 0), apply V → every acc_i = 873, hbits = 16'hFFFF, hbits_fused = 16'hFFFF, mismatch = 0, out_valid one cycle later.
- WEIGHTS all 0, apply V → acc_i = −873, hbits = 16'h0000, mismatch = 0.
- Every WEIGHTS row = 16'hAAAA (odd features +1), apply V → acc_i = 475 − 398 = 77, hbits = 16'hFFFF. Then set THRESH_0 = 77 → bit0 = 1; set THRESH_0 = 78 → bit0 = 0.
- Default params, all features = 127 → s = 2032, acc_i = 1023 (saturated), hbits = 16'hFFFF. All-zero weights, all 127 → acc_i = −1024, hbits = 0.
- Pulse rst_n low while a vector is in flight → outputs go to 0 at once and no out_valid follows. Then stream 3 back-to-back vectors → 3 consecutive out_valid cycles with the correct per-vector results.
- Random WEIGHTS, THRESH and features, 10k vectors → hbits equals the model, hbits_fused equals hbits, and mismatch is never 1.

Source files
------------

// File: rtl/pendig_layer1.sv
// First hidden layer of the pen-digits BNN: 16 binary-weighted dot products over
// 16 unsigned 7-bit features, thresholded into 16 hidden bits by two equivalent paths.
module pendig_layer1 #(
  parameter logic [255:0] WEIGHTS = '1,
  parameter logic [175:0] THRESH  = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [111:0] feat,
  output logic         out_valid,
  output logic [175:0] acc,
  output logic [15:0]  hbits,
  output logic [15:0]  hbits_fused,
  output logic         mismatch
);

  localparam int DATA_W = 7;
  localparam int NF     = 16;
  localparam int NN     = 16;
  localparam int ACC_W  = 11;

  logic         vld_p0_q, vld_p0_d;
  logic [111:0] feat_p0_q, feat_p0_d;
  logic         vld_p1_q, vld_p1_d;
  logic [175:0] acc_p1_q, acc_p1_d;
  logic [15:0]  hbits_p1_q, hbits_p1_d;
  logic [15:0]  hbits_fused_p1_q, hbits_fused_p1_d;
  logic         mismatch_p1_q, mismatch_p1_d;

  logic [175:0] acc_c;
  logic [15:0]  ref_c;
  logic [15:0]  fus_c;

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [11:0] s);
    if (s > 12'sd1023)       return 11'sh3FF;
    else if (s < -12'sd1024) return 11'sh400;
    else                     return s[ACC_W-1:0];
  endfunction

  // Stage p0 -> p1: both threshold paths evaluated from the registered feature vector
  always_comb begin : comb_p0
    logic signed [11:0]      s;
    logic [10:0]             p;
    logic [10:0]             n;
    logic [11:0]             fx;
    logic signed [ACC_W-1:0] th;
    logic signed [12:0]      lhs;
    logic signed [12:0]      rhs;
    acc_c = '0;
    ref_c = '0;
    fus_c = '0;
    s     = '0;
    p     = '0;
    n     = '0;
    fx    = '0;
    th    = '0;
    lhs   = '0;
    rhs   = '0;
    for (int i = 0; i < NN; i++) begin
      s = '0;
      p = '0;
      n = '0;
      for (int j = 0; j < NF; j++) begin
        fx = {5'b0, feat_p0_q[j*DATA_W +: DATA_W]};
        if (WEIGHTS[i*NF + j]) begin
          s = s + $signed(fx);
          p = p + fx[10:0];
        end else begin
          s = s - $signed(fx);
          n = n + fx[10:0];
        end
      end
      th = $signed(THRESH[i*ACC_W +: ACC_W]);
      acc_c[i*ACC_W +: ACC_W] = sat_acc(s);
      // Reference compare uses the unsaturated sum so saturation never flips a bit
      ref_c[i] = (s >= $signed({th[ACC_W-1], th}));
      lhs = $signed({2'b00, p});
      rhs = $signed({2'b00, n}) + $signed({{2{th[ACC_W-1]}}, th});
      fus_c[i] = (lhs >= rhs);
    end
  end

  always_comb begin
    feat_p0_d        = in_valid ? feat : feat_p0_q;
    vld_p0_d         = in_valid;
    vld_p1_d         = vld_p0_q;
    acc_p1_d         = acc_p1_q;
    hbits_p1_d       = hbits_p1_q;
    hbits_fused_p1_d = hbits_fused_p1_q;
    mismatch_p1_d    = mismatch_p1_q;
    if (vld_p0_q) begin
      acc_p1_d         = acc_c;
      hbits_p1_d       = ref_c;
      hbits_fused_p1_d = fus_c;
      mismatch_p1_d    = (ref_c != fus_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q         <= 1'b0;
      feat_p0_q        <= '0;
      vld_p1_q         <= 1'b0;
      acc_p1_q         <= '0;
      hbits_p1_q       <= '0;
      hbits_fused_p1_q <= '0;
      mismatch_p1_q    <= 1'b0;
    end else begin
      vld_p0_q         <= vld_p0_d;
      feat_p0_q        <= feat_p0_d;
      vld_p1_q         <= vld_p1_d;
      acc_p1_q         <= acc_p1_d;
      hbits_p1_q       <= hbits_p1_d;
      hbits_fused_p1_q <= hbits_fused_p1_d;
      mismatch_p1_q    <= mismatch_p1_d;
    end
  end

  assign out_valid   = vld_p1_q;
  assign acc         = acc_p1_q;
  assign hbits       = hbits_p1_q;
  assign hbits_fused = hbits_fused_p1_q;
  assign mismatch    = mismatch_p1_q;

endmodule

// File: tb/tb_pendig_layer1.sv
// Bench for pendig_layer1: six parameter sets share one stimulus stream; a queue of
// issued vectors is checked against an integer model when out_valid appears.
module tb_pendig_layer1;

  localparam int NI = 6;
  localparam logic [255:0] WP [NI] = '{
    {256{1'b1}},
    {256{1'b0}},
    {16{16'hAAAA}},
    {16{16'hAAAA}},
    {16{16'hAAAA}},
    256'h3C5A_96F0_1E2D_B487_C3A5_690F_E1D2_4B78_5A3C_F096_2D1E_87B4_A5C3_0F69_D2E1_784B
  };
  localparam logic [175:0] TP [NI] = '{
    176'd0,
    176'd0,
    176'd0,
    176'd77,
    176'd78,
    176'h9C4E_21B7_F03A_5D68_E217_4C9B_8A05_3F6D_1E72_C4B9_A35F
  };
  localparam int VF [16] = '{80,100,18,98,60,66,100,29,42,0,0,23,42,61,56,98};

  typedef struct {
    logic [111:0] f;
    int           inst;
    int           eacc;
    logic [15:0]  ehb;
  } dir_t;

  typedef struct {
    logic [111:0] f;
    int           cyc;
    int           dir;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [111:0] feat;
  logic         ov [NI];
  logic [175:0] acc_o [NI];
  logic [15:0]  hb_o [NI];
  logic [15:0]  hf_o [NI];
  logic         mm_o [NI];

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  dir_t tbl [9];
  exp_t exp_q [$];
  logic [175:0] last_acc [NI];
  logic [15:0]  last_hb [NI];
  logic [111:0] v_vec, all127, zero_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    pendig_layer1 #(.WEIGHTS(WP[k]), .THRESH(TP[k])) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .feat(feat),
      .out_valid(ov[k]), .acc(acc_o[k]), .hbits(hb_o[k]),
      .hbits_fused(hf_o[k]), .mismatch(mm_o[k])
    );
  end

  task automatic chk(input bit ok, input string nm, input logic [175:0] act,
                     input logic [175:0] expv);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  function automatic void model(input logic [111:0] f, input logic [255:0] w,
                                input logic [175:0] t, output logic [175:0] a,
                                output logic [15:0] hb);
    int s, thr, sat;
    logic [31:0] tmp;
    a = '0;
    hb = '0;
    for (int i = 0; i < 16; i++) begin
      s = 0;
      for (int j = 0; j < 16; j++)
        s = w[i*16+j] ? s + int'(f[j*7 +: 7]) : s - int'(f[j*7 +: 7]);
      thr = int'($signed(t[i*11 +: 11]));
      sat = (s > 1023) ? 1023 : (s < -1024) ? -1024 : s;
      tmp = sat;
      a[i*11 +: 11] = tmp[10:0];
      hb[i] = (s >= thr);
    end
  endfunction

  function automatic logic [175:0] rep_acc(input int v);
    logic [31:0]  tmp;
    logic [175:0] r;
    tmp = v;
    for (int i = 0; i < 16; i++) r[i*11 +: 11] = tmp[10:0];
    return r;
  endfunction

  logic [175:0] m_acc;
  logic [15:0]  m_hb;
  exp_t         e;
  dir_t         d;

  always @(negedge clk) begin
    if (!rst_n)
      for (int k = 0; k < NI; k++) begin
        last_acc[k] = '0;
        last_hb[k]  = '0;
      end
    if (ov[0]) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_valid", 176'd1, 176'd0);
      end else begin
        e = exp_q.pop_front();
        chk(cyc == e.cyc, "latency", 176'(cyc), 176'(e.cyc));
        for (int k = 0; k < NI; k++) begin
          model(e.f, WP[k], TP[k], m_acc, m_hb);
          chk(ov[k] == 1'b1, "out_valid", {175'd0, ov[k]}, 176'd1);
          chk(acc_o[k] == m_acc, "acc", acc_o[k], m_acc);
          chk(hb_o[k] == m_hb, "hbits", {160'd0, hb_o[k]}, {160'd0, m_hb});
          chk(hf_o[k] == m_hb, "hbits_fused", {160'd0, hf_o[k]}, {160'd0, m_hb});
          chk(mm_o[k] == 1'b0, "mismatch", {175'd0, mm_o[k]}, 176'd0);
          last_acc[k] = m_acc;
          last_hb[k]  = m_hb;
        end
        if (e.dir >= 0) begin
          d = tbl[e.dir];
          chk(acc_o[d.inst] == rep_acc(d.eacc), "dir_acc", acc_o[d.inst], rep_acc(d.eacc));
          chk(hb_o[d.inst] == d.ehb, "dir_hbits", {160'd0, hb_o[d.inst]}, {160'd0, d.ehb});
          chk(hf_o[d.inst] == d.ehb, "dir_fused", {160'd0, hf_o[d.inst]}, {160'd0, d.ehb});
        end
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        chk(ov[k] == 1'b0, "valid_low", {175'd0, ov[k]}, 176'd0);
        chk(acc_o[k] == last_acc[k], "hold_acc", acc_o[k], last_acc[k]);
        chk(hb_o[k] == last_hb[k], "hold_hbits", {160'd0, hb_o[k]}, {160'd0, last_hb[k]});
        chk(hf_o[k] == last_hb[k], "hold_fused", {160'd0, hf_o[k]}, {160'd0, last_hb[k]});
      end
    end
  end

  task automatic drive(input logic [111:0] f, input int dir);
    exp_t x;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    feat     = f;
    x.f   = f;
    x.cyc = cyc + 2;
    x.dir = dir;
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [111:0] rf;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    feat     = '0;
    for (int j = 0; j < 16; j++) begin
      v_vec[j*7 +: 7]  = 7'(VF[j]);
      all127[j*7 +: 7] = 7'd127;
    end
    zero_v = '0;
    tbl[0] = '{v_vec,  0,   873, 16'hFFFF};
    tbl[1] = '{v_vec,  1,  -873, 16'h0000};
    tbl[2] = '{v_vec,  2,    77, 16'hFFFF};
    tbl[3] = '{v_vec,  3,    77, 16'hFFFF};
    tbl[4] = '{v_vec,  4,    77, 16'hFFFE};
    tbl[5] = '{all127, 0,  1023, 16'hFFFF};
    tbl[6] = '{all127, 1, -1024, 16'h0000};
    tbl[7] = '{zero_v, 0,     0, 16'hFFFF};
    tbl[8] = '{zero_v, 1,     0, 16'hFFFF};

    #3;
    for (int k = 0; k < NI; k++) begin
      chk(ov[k] == 1'b0 && mm_o[k] == 1'b0, "reset_ctrl", {174'd0, ov[k], mm_o[k]}, 176'd0);
      chk(acc_o[k] == '0 && hb_o[k] == '0 && hf_o[k] == '0, "reset_data", acc_o[k], 176'd0);
    end
    idle(2);
    rst_n = 1'b1;
    idle(1);

    foreach (tbl[i]) begin
      drive(tbl[i].f, i);
      if (i == 3) idle(2);
    end
    idle(3);

    // Vector in flight when reset hits: must vanish without an out_valid
    drive(v_vec, -1);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk(ov[k] == 1'b0, "midreset_valid", {175'd0, ov[k]}, 176'd0);
      chk(acc_o[k] == '0 && hb_o[k] == '0 && hf_o[k] == '0, "midreset_data", acc_o[k], 176'd0);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    drive(v_vec, -1);
    drive(all127, -1);
    drive(zero_v, -1);
    idle(3);

    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        case ($urandom_range(0, 15))
          0:       rf = all127;
          1:       rf = zero_v;
          default: for (int j = 0; j < 16; j++) rf[j*7 +: 7] = 7'($urandom_range(0, 127));
        endcase
        drive(rf, -1);
      end
    end
    idle(4);
    chk(exp_q.size() == 0, "drain", 176'(exp_q.size()), 176'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
